// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write-through bypass, debug port and busy scoreboard
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy1,
  output logic              busy2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic w_wr_ok;
  logic w_iss_ok;
  logic w_ra1_zero;
  logic w_ra2_zero;

  assign w_wr_ok    = we && !(ZR && (wa == '0));
  assign w_iss_ok   = iss_valid && !(ZR && (iss_rd == '0));
  assign w_ra1_zero = ZR && (ra1 == '0);
  assign w_ra2_zero = ZR && (ra2 == '0);

  // Issue is applied after write-back clear so a same-edge issue keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wa] <= wd;
      end
      if (we) begin
        r_busy[wa] <= 1'b0;
      end
      if (w_iss_ok) begin
        r_busy[iss_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd1 = r_regs[ra1];
    if (w_ra1_zero) begin
      rd1 = '0;
    end else if (w_wr_ok && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = r_regs[ra2];
    if (w_ra2_zero) begin
      rd2 = '0;
    end else if (w_wr_ok && (wa == ra2)) begin
      rd2 = wd;
    end
  end

  assign busy1    = r_busy[ra1] && !(we && (wa == ra1));
  assign busy2    = r_busy[ra2] && !(we && (wa == ra2));
  assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb with reference model and parameter sweep
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, iss_rd = '0, dbg_addr = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0, iss_valid = 1'b0;
  logic [31:0] rd1, rd2, dbg_data;
  logic        busy1, busy2;

  logic        s_rst = 1'b1;
  logic [2:0]  s_ra1 = '0, s_ra2 = '0, s_wa = '0, s_iss_rd = '0, s_dbg_addr = '0;
  logic [15:0] s_wd = '0;
  logic        s_we = 1'b0, s_iss_valid = 1'b0;
  logic [15:0] s_rd1, s_rd2, s_dbg_data;
  logic        s_busy1, s_busy2;

  int errs = 0;
  int checks = 0;

  // Reference state: written registers and the set of registers awaiting write-back.
  logic [31:0] m_regs [int];
  bit          m_busy [int];

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy1(busy1), .busy2(busy2), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_s (
    .clk(clk), .rst(s_rst), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .we(s_we), .wa(s_wa), .wd(s_wd), .iss_valid(s_iss_valid), .iss_rd(s_iss_rd),
    .busy1(s_busy1), .busy2(s_busy2), .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    if (m_regs.exists(int'(a))) return m_regs[int'(a)];
    return 32'd0;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return m_busy.exists(int'(a)) && !(we && wa == a);
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] a);
    if (m_regs.exists(int'(a))) return m_regs[int'(a)];
    return 32'd0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rd1"},   rd1,          exp_rd(ra1));
    chk({tag, ".rd2"},   rd2,          exp_rd(ra2));
    chk({tag, ".busy1"}, 32'(busy1),   32'(exp_busy(ra1)));
    chk({tag, ".busy2"}, 32'(busy2),   32'(exp_busy(ra2)));
    chk({tag, ".dbg"},   dbg_data,     exp_dbg(dbg_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_regs.delete();
      m_busy.delete();
    end else begin
      if (we && wa != 5'd0) m_regs[int'(wa)] = wd;
      if (we && m_busy.exists(int'(wa))) m_busy.delete(int'(wa));
      if (iss_valid && iss_rd != 5'd0) m_busy[int'(iss_rd)] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    iss_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    idle();

    // Everything reads zero after reset.
    foreach (ra1[i]) begin end
    for (int a = 0; a < 32; a += 9) begin
      ra1 = 5'(a); ra2 = 5'(a); dbg_addr = 5'(a); #1;
      chk("rst.rd1", rd1, 32'd0);
      chk("rst.busy2", 32'(busy2), 32'd0);
      chk("rst.dbg", dbg_data, 32'd0);
    end

    // Bypass visible the same cycle, debug port a cycle later.
    we = 1'b1; wa = 5'd8; wd = 32'hDEADBEEF; ra1 = 5'd8; dbg_addr = 5'd8; #1;
    chk("byp.rd1", rd1, 32'hDEADBEEF);
    chk("byp.dbg_before", dbg_data, 32'd0);
    check_all("byp");
    tick();
    idle(); #1;
    chk("byp.dbg_after", dbg_data, 32'hDEADBEEF);

    // Register zero ignores writes and issues.
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0; ra2 = 5'd0; dbg_addr = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0; #1;
    chk("zero.rd1_same", rd1, 32'd0);
    chk("zero.rd2_same", rd2, 32'd0);
    tick();
    idle(); #1;
    chk("zero.rd1", rd1, 32'd0);
    chk("zero.rd2", rd2, 32'd0);
    chk("zero.dbg", dbg_data, 32'd0);
    chk("zero.busy1", 32'(busy1), 32'd0);

    // Issue then write-back resolves the hazard in the write cycle.
    iss_valid = 1'b1; iss_rd = 5'd5; #1;
    tick();
    idle(); ra1 = 5'd5; #1;
    chk("haz.busy_set", 32'(busy1), 32'd1);
    we = 1'b1; wa = 5'd5; wd = 32'h55; #1;
    chk("haz.busy_wb", 32'(busy1), 32'd0);
    chk("haz.rd1_wb", rd1, 32'h55);
    tick();
    idle(); #1;
    chk("haz.busy_after", 32'(busy1), 32'd0);
    chk("haz.rd1_after", rd1, 32'h55);

    // Same-edge issue and write: data updates, busy stays set.
    iss_valid = 1'b1; iss_rd = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'hA5; #1;
    tick();
    idle(); ra1 = 5'd7; ra2 = 5'd7; dbg_addr = 5'd7; #1;
    chk("same.rd1", rd1, 32'hA5);
    chk("same.dbg", dbg_data, 32'hA5);
    chk("same.busy1", 32'(busy1), 32'd1);
    chk("same.busy2", 32'(busy2), 32'd1);

    // Reset mid-operation drops pending busy bits and data.
    iss_valid = 1'b1; iss_rd = 5'd3; tick();
    iss_rd = 5'd4; tick();
    idle(); ra1 = 5'd3; ra2 = 5'd4; #1;
    chk("mrst.busy1_pre", 32'(busy1), 32'd1);
    chk("mrst.busy2_pre", 32'(busy2), 32'd1);
    rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h99; iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle(); #1;
    chk("mrst.busy1", 32'(busy1), 32'd0);
    chk("mrst.busy2", 32'(busy2), 32'd0);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); dbg_addr = 5'(a); #1;
      chk("mrst.rd1", rd1, 32'd0);
      chk("mrst.dbg", dbg_data, 32'd0);
    end
    ra1 = 5'd9; #1;
    chk("mrst.ign_busy", 32'(busy1), 32'd0);
    we = 1'b1; wa = 5'd3; wd = 32'h33; ra1 = 5'd3; #1;
    chk("mrst.wb_busy", 32'(busy1), 32'd0);
    chk("mrst.wb_rd", rd1, 32'h33);
    tick();
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      we        = $urandom_range(0, 1) == 1;
      wa        = 5'($urandom_range(0, 31));
      wd        = $urandom;
      iss_valid = $urandom_range(0, 2) != 0;
      iss_rd    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1       = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2       = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      dbg_addr  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      #1;
      check_all("rnd");
      tick();
    end
    idle();

    // Narrow instance without a hardwired zero register.
    s_rst = 1'b0;
    s_we = 1'b1; s_wa = 3'd0; s_wd = 16'hFFFF; s_ra1 = 3'd0; s_ra2 = 3'd0; s_dbg_addr = 3'd0; #1;
    chk("sw.byp0", 32'(s_rd1), 32'hFFFF);
    tick();
    s_we = 1'b0; #1;
    chk("sw.rd0", 32'(s_rd1), 32'hFFFF);
    chk("sw.dbg0", 32'(s_dbg_data), 32'hFFFF);
    s_we = 1'b1; s_wa = 3'd7; s_wd = 16'h1234;
    tick();
    s_we = 1'b0; s_ra1 = 3'd0; s_ra2 = 3'd7; #1;
    chk("sw.noalias0", 32'(s_rd1), 32'hFFFF);
    chk("sw.rd7", 32'(s_rd2), 32'h1234);
    s_iss_valid = 1'b1; s_iss_rd = 3'd0;
    tick();
    s_iss_valid = 1'b0; #1;
    chk("sw.busy0", 32'(s_busy1), 32'd1);
    chk("sw.busy2_7", 32'(s_busy2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, giving the register address width; depth is 2**ADDR_W.
REQ-003 The module SHALL have parameter ZERO_REG, default 1, which when 1 hardwires register 0 to zero.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ra1, ra2  input  ADDR_W each  read port addresses.
REQ-007 rd1, rd2  output  DATA_W each  read data.
REQ-008 we, wa, wd  input  1 / ADDR_W / DATA_W  write-back enable, address and data.
REQ-009 iss_valid, iss_rd  input  1 / ADDR_W  issue of an instruction that will later write iss_rd.
REQ-010 busy1, busy2  output  1 each  register at ra1 / ra2 has a pending write (scoreboard bit).
REQ-011 dbg_addr  input  ADDR_W, and dbg_data  output  DATA_W  combinational debug read port, no bypass.

Function
REQ-012 The register array SHALL be written on the rising clk edge when we=1: regs[wa] <= wd.
REQ-013 When ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0 on all ports.
REQ-014 rd1/rd2 SHALL be combinational: if we=1, wa==raN and the write is not discarded, rdN = wd (write-through bypass); otherwise rdN = regs[raN].
REQ-015 dbg_data SHALL equal regs[dbg_addr] with no bypass, i.e. new data appears the cycle after the write.
REQ-016 A scoreboard of 2**ADDR_W busy bits SHALL be kept, one per register.
REQ-017 On a rising edge with iss_valid=1, busy[iss_rd] SHALL be set to 1.
REQ-018 On a rising edge with we=1, busy[wa] SHALL be cleared to 0.
REQ-019 Simultaneous iss_valid and we to the same address SHALL leave busy set (issue wins; the write still updates data).
REQ-020 When ZERO_REG=1, busy[0] SHALL never be set and SHALL read 0.
REQ-021 busyN SHALL be combinational: busy[raN] AND NOT (we=1 AND wa==raN), so a same-cycle write-back resolves the hazard together with the REQ-014 bypass.
REQ-022 Two read ports reading the same address SHALL return identical data and busy values.
REQ-023 A write to a register whose busy bit is 0 SHALL still update data (no scoreboard gating of writes).

Reset
REQ-024 On a rising edge with rst=1, all registers and all busy bits SHALL be cleared to 0; we and iss_valid in that cycle SHALL be ignored.
REQ-025 After reset, rd1, rd2, dbg_data, busy1 and busy2 SHALL all be 0 for any address until a write or issue occurs.
REQ-026 Reset asserted mid-operation SHALL discard all pending busy bits; a later we to a formerly busy register SHALL behave as REQ-018 and REQ-023.

Verification
REQ-027 Reset, then write wd=0xDEADBEEF to wa=8 -> same cycle rd1 (ra1=8) = 0xDEADBEEF via bypass; dbg_data(8) = 0 that cycle and 0xDEADBEEF the next cycle.
REQ-028 Write 0x12345678 to wa=0 with ZERO_REG=1 -> rd1, rd2 and dbg_data at address 0 stay 0; issue to rd 0 -> busy1 stays 0.
REQ-029 Issue rd=5; the next cycle ra1=5 -> busy1=1; then we to wa=5 with wd=0x55 -> busy1=0 in that cycle and rd1=0x55; busy stays 0 afterwards.
REQ-030 Issue rd=7 and write wa=7 wd=0xA5 on the same edge -> regs[7]=0xA5, busy[7]=1 afterwards.
REQ-031 Issue rd=3 and rd=4 in consecutive cycles, then assert rst for 1 cycle -> busy1/busy2 at 3 and 4 = 0, and all registers read 0.
REQ-032 Parameter sweep DATA_W=16, ADDR_W=3, ZERO_REG=0 -> write 0xFFFF to address 0 -> read returns 0xFFFF; write to address 7 does not alias address 0.
